spi_baud_generator: RTL

- Generates the SPI serial clock and one-cycle sample/shift strobes for master-mode transfers.
- Computes the baud-rate divisor from the prescaler fields and drives the divisor to the slave-select stage, which uses it to size the frame window.
- Sits between the APB register file (supplies `sppr`, `spr`, `cpol`, `cpha`, mode bits) and the slave-select/shift-register stages (consume `BaudRateDivisor`, `sclk`, strobes).

---
 rtl/spi_pkg.sv | 11 +
 rtl/spi_baud_generator.sv | 66 ++++++
 2 files changed

// File: rtl/spi_pkg.sv
// Shared SPI constants: operating-mode encodings and the baud divisor width.
package spi_pkg;

   localparam int unsigned DIV_W = 12;
   localparam int unsigned CNT_W = 12;

   localparam logic [1:0] SPI_RUN  = 2'b00;
   localparam logic [1:0] SPI_WAIT = 2'b01;
   localparam logic [1:0] SPI_STOP = 2'b10;

endpackage

// File: rtl/spi_baud_generator.sv
// Master-mode SPI serial clock generator with one-cycle sample/shift strobes
// and the combinational baud-rate divisor shared with the slave-select stage.
module spi_baud_generator
   import spi_pkg::*;
(
   input  logic             pclk,
   input  logic             preset,
   input  logic             mstr,
   input  logic             spiswai,
   input  logic [1:0]       spi_mode,
   input  logic             ss,
   input  logic             cpol,
   input  logic             cpha,
   input  logic [2:0]       sppr,
   input  logic [2:0]       spr,
   output logic [DIV_W-1:0] BaudRateDivisor,
   output logic             sclk,
   output logic             sample_flag,
   output logic             shift_flag
);

   logic [3:0]       sppr_p1;
   logic [3:0]       spr_p1;
   logic [DIV_W-1:0] half;
   logic [CNT_W-1:0] count;
   logic             en;
   logic             wrap;
   logic             leading;

   // (sppr+1) * 2^(spr+1); the largest value, 8 << 8 = 2048, fits in 12 bits
   assign sppr_p1         = {1'b0, sppr} + 4'd1;
   assign spr_p1          = {1'b0, spr} + 4'd1;
   assign BaudRateDivisor = DIV_W'(sppr_p1) << spr_p1;
   assign half            = BaudRateDivisor >> 1;

   assign en = mstr & ~spiswai & ((spi_mode == SPI_RUN) | (spi_mode == SPI_WAIT)) & ~ss;

   // '>=' lets a shrinking divisor wrap immediately instead of running away
   assign wrap    = (count >= CNT_W'(half - DIV_W'(1)));
   assign leading = (sclk == cpol);

   always_ff @(posedge pclk or posedge preset) begin
      if (preset) begin
         count       <= '0;
         sclk        <= 1'b0;
         sample_flag <= 1'b0;
         shift_flag  <= 1'b0;
      end else if (!en) begin
         count       <= '0;
         sclk        <= cpol;
         sample_flag <= 1'b0;
         shift_flag  <= 1'b0;
      end else if (wrap) begin
         count       <= '0;
         sclk        <= ~sclk;
         // cpha=0 samples on the leading edge, cpha=1 on the trailing edge
         sample_flag <= leading ^ cpha;
         shift_flag  <= ~(leading ^ cpha);
      end else begin
         count       <= count + CNT_W'(1);
         sample_flag <= 1'b0;
         shift_flag  <= 1'b0;
      end
   end

endmodule
